pwm_level_decoder: RTL and testbench

- Receive-side counterpart of the lamp PWM generator: samples a PWM line and measures its period and high time.
- Quantises the measured duty to the lamp brightness code: 0 = off, 1..4 = 25/50/75/100 %.
- Used for loop-back checking of the light output and for driving a level display.
- Single clock domain; the PWM input is treated as asynchronous.

---
 rtl/pwm_level_decoder_if.sv | 18 +
 rtl/pwm_level_decoder.sv | 146 ++++++++++++++
 tb/tb_pwm_level_decoder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_level_decoder_if.sv
// Measurement result bus of the PWM level decoder: period, high time, level and update strobes.
interface pwm_level_decoder_if #(
  parameter int CNT_W = 11
);
  logic [CNT_W-1:0] o_period;
  logic [CNT_W-1:0] o_high;
  logic [2:0]       o_level;
  logic             o_valid;
  logic             o_timeout;

  modport master (
    output o_period, o_high, o_level, o_valid, o_timeout
  );

  modport slave (
    input o_period, o_high, o_level, o_valid, o_timeout
  );
endinterface

// File: rtl/pwm_level_decoder.sv
// Measures period and high time of an asynchronous PWM line and quantises the duty to 0..4.
// Optional PWM_LEVEL_HYST_EN: o_level only moves after two consecutive identical new results.
//
// state | meaning
// SYNC  | waiting for a first rising edge; no valid measurement in progress
// MEAS  | measuring from the last rising edge; next rising edge publishes a result
module pwm_level_decoder #(
  parameter int CNT_W      = 11,
  parameter int MAX_PERIOD = 1024
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_pwm,
  pwm_level_decoder_if.master res
);

  typedef enum logic {SYNC, MEAS} state_t;

  localparam int               QW      = CNT_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MAX_P   = CNT_W'(MAX_PERIOD);

  state_t           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic             rise;
  logic             tmo;
  logic             upd;
  logic [2:0]       q_meas;
  logic [2:0]       new_lvl;

`ifdef PWM_LEVEL_HYST_EN
  logic [2:0]       pend_lvl;
  logic             pend_vld;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CNT_MAX) ? x : x + 1'b1;
  endfunction

  // Duty thresholds at the 12.5/37.5/62.5/87.5 % midpoints, compared as 8H against kP.
  function automatic logic [2:0] quantise(input logic [CNT_W-1:0] h,
                                          input logic [CNT_W-1:0] p);
    logic [QW-1:0] h8, p1, p3, p5, p7;
    h8 = {h, 3'b000};
    p1 = QW'(p);
    p3 = p1 + (p1 << 1);
    p5 = p1 + (p1 << 2);
    p7 = (p1 << 3) - p1;
    if (h8 < p1)      return 3'd0;
    else if (h8 < p3) return 3'd1;
    else if (h8 < p5) return 3'd2;
    else if (h8 < p7) return 3'd3;
    else              return 3'd4;
  endfunction

  // Synchroniser is left unreset so a reset does not fabricate an edge on a high line.
  always_ff @(posedge i_clk) begin
    s1 <= i_pwm;
    s2 <= s1;
    s3 <= s2;
  end

  always_comb begin
    rise    = s2 & ~s3;
    tmo     = (per_cnt == MAX_P);
    q_meas  = quantise(hi_cnt, per_cnt);
    upd     = (rise && state == MEAS) || (tmo && !rise);
    new_lvl = rise ? q_meas : (s2 ? 3'd4 : 3'd0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state         <= SYNC;
      per_cnt       <= '0;
      hi_cnt        <= '0;
      res.o_period  <= '0;
      res.o_high    <= '0;
      res.o_level   <= '0;
      res.o_valid   <= 1'b0;
      res.o_timeout <= 1'b0;
`ifdef PWM_LEVEL_HYST_EN
      pend_lvl      <= '0;
      pend_vld      <= 1'b0;
`endif
    end else begin
      res.o_valid <= 1'b0;
      case (state)
        SYNC: begin
          if (rise) begin
            per_cnt <= CNT_W'(1);
            hi_cnt  <= CNT_W'(1);
            state   <= MEAS;
          end else if (tmo) begin
            res.o_period  <= MAX_P;
            res.o_high    <= s2 ? MAX_P : '0;
            res.o_timeout <= 1'b1;
            res.o_valid   <= 1'b1;
            per_cnt       <= '0;
          end else begin
            per_cnt <= sat_inc(per_cnt);
          end
        end
        MEAS: begin
          if (rise) begin
            res.o_period  <= per_cnt;
            res.o_high    <= hi_cnt;
            res.o_timeout <= 1'b0;
            res.o_valid   <= 1'b1;
            per_cnt       <= CNT_W'(1);
            hi_cnt        <= CNT_W'(1);
          end else if (tmo) begin
            res.o_period  <= MAX_P;
            res.o_high    <= s2 ? MAX_P : '0;
            res.o_timeout <= 1'b1;
            res.o_valid   <= 1'b1;
            per_cnt       <= '0;
            state         <= SYNC;
          end else begin
            per_cnt <= sat_inc(per_cnt);
            if (s2) hi_cnt <= sat_inc(hi_cnt);
          end
        end
        default: state <= SYNC;
      endcase

      if (upd) begin
`ifdef PWM_LEVEL_HYST_EN
        if (new_lvl == res.o_level) begin
          pend_vld <= 1'b0;
        end else if (pend_vld && pend_lvl == new_lvl) begin
          res.o_level <= new_lvl;
          pend_vld    <= 1'b0;
        end else begin
          pend_lvl <= new_lvl;
          pend_vld <= 1'b1;
        end
`else
        res.o_level <= new_lvl;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pwm_level_decoder.sv
// Directed bench for pwm_level_decoder: duty table, reset, timeout, hysteresis and edge-coincidence cases.
module tb_pwm_level_decoder;

  localparam int CNT_W  = 11;
  localparam int MAXP   = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pwm = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic prev_v = 1'b0;

  typedef struct {
    int per;
    int hi;
    int n;
    int lvl;
  } vec_t;

  typedef struct {
    int cyc;
    int per;
    int hi;
    int lvl;
    int tmo;
  } ev_t;

  vec_t tv[11];
  ev_t  evq[$];

  pwm_level_decoder_if #(.CNT_W(CNT_W)) bus();

  pwm_level_decoder #(.CNT_W(CNT_W), .MAX_PERIOD(MAXP)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_pwm   (pwm),
    .res     (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_valid) begin
      total++;
      if (prev_v !== 1'b0) begin
        bad++;
        $display("FAIL valid_back_to_back: got prev=%b required 0 at cyc %0d", prev_v, cyc);
      end
      evq.push_back('{cyc: cyc, per: int'(bus.o_period), hi: int'(bus.o_high),
                      lvl: int'(bus.o_level), tmo: int'(bus.o_timeout)});
    end
    prev_v = bus.o_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_period"},  int'(bus.o_period), 0);
    chk({tag, "_high"},    int'(bus.o_high), 0);
    chk({tag, "_level"},   int'(bus.o_level), 0);
    chk({tag, "_valid"},   int'(bus.o_valid), 0);
    chk({tag, "_timeout"}, int'(bus.o_timeout), 0);
  endtask

  task automatic do_reset(input logic lvl);
    @(negedge clk);
    rst = 1'b0;
    pwm = lvl;
    repeat (4) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drive(input int per, input int hi, input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < per; c++) begin
        pwm = (c < hi);
        @(negedge clk);
      end
    end
  endtask

  task automatic check_timeouts(input string tag, input int hi_exp, input int lvl_exp);
    for (int i = 0; i < 4000 && evq.size() < 3; i++) @(negedge clk);
    chk({tag, "_count"}, evq.size(), 3);
    if (evq.size() >= 3) begin
      chk({tag, "_tmo0"},   evq[0].tmo, 1);
      chk({tag, "_per0"},   evq[0].per, MAXP);
      chk({tag, "_hi0"},    evq[0].hi, hi_exp);
      chk({tag, "_lvl1"},   evq[1].lvl, lvl_exp);
      chk({tag, "_tmo1"},   evq[1].tmo, 1);
      chk({tag, "_gap01"},  evq[1].cyc - evq[0].cyc, MAXP + 1);
      chk({tag, "_gap12"},  evq[2].cyc - evq[1].cyc, MAXP + 1);
    end
  endtask

  initial begin
    int c_a;
    int mid_lvl;

    tv[0]  = '{per: 100, hi: 50,  n: 3, lvl: 2};
    tv[1]  = '{per: 200, hi: 50,  n: 3, lvl: 1};
    tv[2]  = '{per: 200, hi: 150, n: 3, lvl: 3};
    tv[3]  = '{per: 200, hi: 20,  n: 3, lvl: 0};
    tv[4]  = '{per: 200, hi: 25,  n: 3, lvl: 1};
    tv[5]  = '{per: 80,  hi: 9,   n: 3, lvl: 0};
    tv[6]  = '{per: 100, hi: 87,  n: 3, lvl: 3};
    tv[7]  = '{per: 100, hi: 88,  n: 3, lvl: 4};
    tv[8]  = '{per: 100, hi: 25,  n: 3, lvl: 1};
    tv[9]  = '{per: 100, hi: 75,  n: 3, lvl: 3};
    tv[10] = '{per: 8,   hi: 1,   n: 3, lvl: 1};

    repeat (4) @(negedge clk);
    chk_outputs_zero("por");
    rst = 1'b1;

    foreach (tv[i]) begin
      do_reset(1'b0);
      evq.delete();
      drive(tv[i].per, tv[i].hi, tv[i].n + 1);
      chk($sformatf("vec%0d_count", i), evq.size(), tv[i].n);
      if (evq.size() >= 2) begin
        chk($sformatf("vec%0d_period", i), evq[evq.size()-1].per, tv[i].per);
        chk($sformatf("vec%0d_high", i),   evq[evq.size()-1].hi, tv[i].hi);
        chk($sformatf("vec%0d_level", i),  evq[evq.size()-1].lvl, tv[i].lvl);
        chk($sformatf("vec%0d_tmo", i),    evq[evq.size()-1].tmo, 0);
        chk($sformatf("vec%0d_gap", i),    evq[evq.size()-1].cyc - evq[evq.size()-2].cyc,
            tv[i].per);
      end
    end

    // Reset in the low phase of a running 100/50 stream.
    do_reset(1'b0);
    drive(100, 50, 3);
    for (int c = 0; c < 70; c++) begin
      pwm = (c < 50);
      @(negedge clk);
    end
    rst = 1'b0;
    pwm = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk_outputs_zero("midrst");
    evq.delete();
    repeat (29) @(negedge clk);
    c_a = cyc;
    drive(100, 50, 3);
    chk("midrst_count", evq.size(), 2);
    if (evq.size() >= 1) begin
      chk("midrst_late", int'((evq[0].cyc - c_a) >= 100 && (evq[0].cyc - c_a) <= 105), 1);
      chk("midrst_period", evq[0].per, 100);
      chk("midrst_high", evq[0].hi, 50);
    end

    // Single odd period, then two in a row.
`ifdef PWM_LEVEL_HYST_EN
    mid_lvl = 2;
`else
    mid_lvl = 3;
`endif
    do_reset(1'b0);
    drive(100, 50, 4);
    evq.delete();
    drive(100, 80, 1);
    drive(100, 50, 2);
    chk("hyst1_count", evq.size(), 3);
    if (evq.size() >= 3) begin
      chk("hyst1_lvl0", evq[0].lvl, 2);
      chk("hyst1_lvl1", evq[1].lvl, mid_lvl);
      chk("hyst1_hi1",  evq[1].hi, 80);
      chk("hyst1_lvl2", evq[2].lvl, 2);
    end
    evq.delete();
    drive(100, 80, 2);
    drive(100, 50, 1);
    chk("hyst2_count", evq.size(), 3);
    if (evq.size() >= 3) begin
      chk("hyst2_lvl0", evq[0].lvl, 2);
      chk("hyst2_lvl1", evq[1].lvl, mid_lvl);
      chk("hyst2_lvl2", evq[2].lvl, 3);
    end

    // Constant lines.
    do_reset(1'b1);
    evq.delete();
    check_timeouts("tmo_high", MAXP, 4);
    do_reset(1'b0);
    evq.delete();
    check_timeouts("tmo_low", 0, 0);

    // Rise on the same cycle the period counter reaches MAX_PERIOD.
    do_reset(1'b0);
    evq.delete();
    drive(MAXP, MAXP / 2, 3);
    chk("coin_count", evq.size(), 2);
    if (evq.size() >= 2) begin
      chk("coin_per0", evq[0].per, MAXP);
      chk("coin_tmo0", evq[0].tmo, 0);
      chk("coin_per1", evq[1].per, MAXP);
      chk("coin_tmo1", evq[1].tmo, 0);
      chk("coin_lvl1", evq[1].lvl, 2);
      chk("coin_gap",  evq[1].cyc - evq[0].cyc, MAXP);
    end

    // One clock longer than MAX_PERIOD: timeout fires one cycle ahead of the rise.
    do_reset(1'b0);
    evq.delete();
    drive(MAXP + 1, 500, 2);
    pwm = 1'b0;
    repeat (10) @(negedge clk);
    chk("over_count", evq.size(), 2);
    if (evq.size() >= 2) begin
      chk("over_tmo0", evq[0].tmo, 1);
      chk("over_hi0",  evq[0].hi, 0);
      chk("over_per1", evq[1].per, MAXP);
      chk("over_tmo1", evq[1].tmo, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
